// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor. A WIDTH-bit add is cut into WIDTH/SLICE ripple
// slices, one slice per stage. Each beat carries its own valid bit, its remaining operands,
// the sum slices completed so far and the carry into the next slice. The whole pipe freezes
// when the output beat is not taken, so bubbles are kept and never compressed.
module rca_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / SLICE;

  // Per-stage beat state
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cry_q, cry_d;
  logic [WIDTH-1:0]  opa_q [STAGES];
  logic [WIDTH-1:0]  opa_d [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];
  logic [WIDTH-1:0]  opb_d [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic              ovf_q, ovf_d;

  // Stage inputs (what arrives from upstream) and stage results
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;
  logic [WIDTH-1:0]  add_s [STAGES];
  logic [STAGES-1:0] add_c;
  logic              add_ovf;

  logic              stall;

  // The pipe stalls only when a result is presented and not taken
  always_comb begin
    stall    = vld_q[STAGES-1] & ~out_ready;
    in_ready = ~stall;
  end

  // Route each stage's inputs: stage 0 from the ports (B inverted for subtract), others from the
  // previous stage register
  always_comb begin
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_s[0] = '0;
    src_c[0] = sub | ci;
    src_v[0] = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_a[k] = opa_q[k-1];
      src_b[k] = opb_q[k-1];
      src_s[k] = sum_q[k-1];
      src_c[k] = cry_q[k-1];
      src_v[k] = vld_q[k-1];
    end
  end

  // Ripple-add one SLICE-bit slice per stage; the MSB carry-in is captured for overflow
  always_comb begin : slice_add
    logic        c;
    logic        c_msb;
    int unsigned idx;
    c_msb = 1'b0;
    c     = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      add_s[k] = src_s[k];
      c        = src_c[k];
      for (int unsigned i = 0; i < SLICE; i++) begin
        idx = k * SLICE + i;
        if (idx == WIDTH - 1) c_msb = c;
        add_s[k][idx] = src_a[k][idx] ^ src_b[k][idx] ^ c;
        c = (src_a[k][idx] & src_b[k][idx]) | (c & (src_a[k][idx] ^ src_b[k][idx]));
      end
      add_c[k] = c;
    end
    add_ovf = c_msb ^ add_c[STAGES-1];
  end

  // Next state: every stage advances together, or all hold during a stall
  always_comb begin
    vld_d = vld_q;
    cry_d = cry_q;
    ovf_d = ovf_q;
    for (int unsigned k = 0; k < STAGES; k++) begin
      opa_d[k] = opa_q[k];
      opb_d[k] = opb_q[k];
      sum_d[k] = sum_q[k];
    end
    if (!stall) begin
      vld_d = src_v;
      cry_d = add_c;
      ovf_d = add_ovf;
      for (int unsigned k = 0; k < STAGES; k++) begin
        opa_d[k] = src_a[k];
        opb_d[k] = src_b[k];
        sum_d[k] = add_s[k];
      end
    end
  end

  // Stage registers; reset discards every beat in flight and clears all data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      cry_q <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cry_q <= cry_d;
      ovf_q <= ovf_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  // Outputs come straight from the last stage register
  always_comb begin
    out_valid = vld_q[STAGES-1];
    s         = sum_q[STAGES-1];
    co        = cry_q[STAGES-1];
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_rca_pipe.sv
// Scoreboard bench for rca_pipe: drivers push expected results into per-DUT queues, monitors pop
// and compare whenever a result transfers. Latency is counted from the cycle a beat is presented
// and taken to the cycle its result is first visible.
module tb_rca_pipe;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ovf;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk;
  logic reset_n;

  // 32/4 main instance
  logic        m_in_valid, m_in_ready, m_ci, m_sub, m_out_valid, m_out_ready, m_co, m_ovf;
  logic [31:0] m_a, m_b, m_s;
  // 8/8 single-stage instance
  logic        x_in_valid, x_in_ready, x_ci, x_sub, x_out_valid, x_co, x_ovf;
  logic [7:0]  x_a, x_b, x_s;
  // 16/1 bit-per-stage instance
  logic        y_in_valid, y_in_ready, y_ci, y_sub, y_out_valid, y_co, y_ovf;
  logic [15:0] y_a, y_b, y_s;

  exp_t qm[$];
  exp_t qx[$];
  exp_t qy[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   rnd_ready = 0;

  rca_pipe #(.WIDTH(32), .SLICE(4)) u_main (
    .clk(clk), .reset_n(reset_n), .in_valid(m_in_valid), .in_ready(m_in_ready), .a(m_a), .b(m_b),
    .ci(m_ci), .sub(m_sub), .out_valid(m_out_valid), .out_ready(m_out_ready), .s(m_s), .co(m_co),
    .ovf(m_ovf)
  );

  rca_pipe #(.WIDTH(8), .SLICE(8)) u_w8 (
    .clk(clk), .reset_n(reset_n), .in_valid(x_in_valid), .in_ready(x_in_ready), .a(x_a), .b(x_b),
    .ci(x_ci), .sub(x_sub), .out_valid(x_out_valid), .out_ready(1'b1), .s(x_s), .co(x_co),
    .ovf(x_ovf)
  );

  rca_pipe #(.WIDTH(16), .SLICE(1)) u_w16 (
    .clk(clk), .reset_n(reset_n), .in_valid(y_in_valid), .in_ready(y_in_ready), .a(y_a), .b(y_b),
    .ci(y_ci), .sub(y_sub), .out_valid(y_out_valid), .out_ready(1'b1), .s(y_s), .co(y_co),
    .ovf(y_ovf)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] s, input logic co, input logic ovf, input bit lat);
    exp_t e;
    e.s = s; e.co = co; e.ovf = ovf; e.acc = 0; e.lat = lat;
    return e;
  endfunction

  // Reference: plain wide addition; signed overflow from operand/result sign bits
  function automatic exp_t model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sub, input bit lat);
    exp_t        e;
    logic [32:0] t;
    logic [31:0] mask, bb, aa;
    mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    aa    = a & mask;
    bb    = (sub ? ~b : b) & mask;
    t     = {1'b0, aa} + {1'b0, bb} + {32'd0, (sub | ci)};
    e.s   = t[31:0] & mask;
    e.co  = t[w];
    e.ovf = (aa[w-1] == bb[w-1]) && (e.s[w-1] != aa[w-1]);
    e.acc = 0;
    e.lat = lat;
    return e;
  endfunction

  task automatic score(input string tag, input exp_t e, input logic [31:0] s, input logic co,
                       input logic ovf, input int stages);
    chk({tag, " s"}, s, e.s);
    chk({tag, " co"}, co, e.co);
    chk({tag, " ovf"}, ovf, e.ovf);
    if (e.lat) chk({tag, " latency"}, cyc - e.acc, stages);
  endtask

  // Main monitor: scoreboard pop on transfer, and hold check across stalled cycles
  initial begin
    logic        ps;
    logic [33:0] pv;
    exp_t        e;
    ps = 0;
    pv = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) ps = 0;
      else begin
        if (ps) chk("main stall hold", {m_out_valid, m_ovf, m_co, m_s}, {1'b1, pv});
        if (m_out_valid && m_out_ready) begin
          if (qm.size() == 0) begin
            tests++; fails++;
            $display("FAIL main unexpected beat: got s=%h, expected none", m_s);
          end else begin
            e = qm.pop_front();
            score("main", e, m_s, m_co, m_ovf, 8);
          end
        end
        ps = m_out_valid && !m_out_ready;
        pv = {m_ovf, m_co, m_s};
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && x_out_valid) begin
        if (qx.size() == 0) begin
          tests++; fails++;
          $display("FAIL w8 unexpected beat: got s=%h, expected none", x_s);
        end else begin
          e = qx.pop_front();
          score("w8", e, {24'd0, x_s}, x_co, x_ovf, 1);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && y_out_valid) begin
        if (qy.size() == 0) begin
          tests++; fails++;
          $display("FAIL w16 unexpected beat: got s=%h, expected none", y_s);
        end else begin
          e = qy.pop_front();
          score("w16", e, {16'd0, y_s}, y_co, y_ovf, 16);
        end
      end
    end
  end

  // Random backpressure on the main instance while enabled
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) m_out_ready = 1'($urandom_range(0, 1));
  end

  // Present one beat; call back-to-back for full-rate streams
  task automatic send_m(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic sub, input exp_t e);
    int n;
    m_a = a; m_b = b; m_ci = ci; m_sub = sub; m_in_valid = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_in_ready && n < 200);
    if (!m_in_ready) begin
      tests++; fails++;
      $display("FAIL main accept timeout: got in_ready=0, expected 1");
    end else begin
      e.acc = cyc;
      qm.push_back(e);
    end
    @(posedge clk);
    #1;
    m_in_valid = 0;
  endtask

  task automatic send_x(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic sub, input exp_t e);
    x_a = a; x_b = b; x_ci = ci; x_sub = sub; x_in_valid = 1;
    @(negedge clk);
    chk("w8 in_ready", x_in_ready, 1'b1);
    e.acc = cyc;
    qx.push_back(e);
    @(posedge clk);
    #1;
    x_in_valid = 0;
  endtask

  task automatic send_y(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic sub, input exp_t e);
    y_a = a; y_b = b; y_ci = ci; y_sub = sub; y_in_valid = 1;
    @(negedge clk);
    e.acc = cyc;
    qy.push_back(e);
    @(posedge clk);
    #1;
    y_in_valid = 0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((qm.size() + qx.size() + qy.size()) != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if ((qm.size() + qx.size() + qy.size()) != 0) begin
      fails++;
      $display("FAIL drain: got %0d results outstanding, expected 0",
               qm.size() + qx.size() + qy.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rc, rs;
    m_in_valid = 0; m_a = '0; m_b = '0; m_ci = 0; m_sub = 0; m_out_ready = 1;
    x_in_valid = 0; x_a = '0; x_b = '0; x_ci = 0; x_sub = 0;
    y_in_valid = 0; y_a = '0; y_b = '0; y_ci = 0; y_sub = 0;
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", m_out_valid, 1'b0);
    chk("reset s", m_s, 32'd0);
    chk("reset co", m_co, 1'b0);
    chk("reset ovf", m_ovf, 1'b0);
    chk("reset in_ready", m_in_ready, 1'b1);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;

    // Full carry propagation through all eight stages
    send_m(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, mk(32'h0000_0000, 1, 0, 1));
    wait_drain();

    // Back-to-back directed beats with out_ready high: exact latency on each proves full rate
    send_m(32'h0000_0005, 32'h0000_0007, 0, 1, mk(32'hFFFF_FFFE, 0, 0, 1));
    send_m(32'h8000_0000, 32'h0000_0001, 0, 1, mk(32'h7FFF_FFFF, 1, 1, 1));
    send_m(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, mk(32'h8000_0000, 0, 1, 1));
    send_m(32'h0000_0000, 32'h0000_0000, 1, 0, mk(32'h0000_0001, 0, 0, 1));
    send_m(32'h0000_0003, 32'h0000_0003, 1, 1, mk(32'h0000_0000, 1, 0, 1));
    send_m(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, mk(32'hFFFF_FFFF, 1, 0, 1));
    send_m(32'h1234_5678, 32'h1111_1111, 0, 0, mk(32'h2345_6789, 0, 0, 1));
    send_m(32'h0000_000F, 32'h0000_0001, 0, 0, mk(32'h0000_0010, 0, 0, 1));
    wait_drain();

    // Random traffic with random gaps and random backpressure
    rnd_ready = 1;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_m(ra, rb, rc, rs, model(32, ra, rb, rc, rs, 0));
    end
    rnd_ready = 0;
    m_out_ready = 1;
    wait_drain();

    // Reset with five beats in flight; nothing of them may ever emerge
    for (int i = 1; i <= 5; i++)
      send_m(32'h1111_1111 * i, 32'h0000_0003, 0, 0, mk(32'h1111_1111 * i + 3, 0, 0, 0));
    #1;
    reset_n = 0;
    qm.delete();
    #1;
    chk("midreset out_valid", m_out_valid, 1'b0);
    chk("midreset s", m_s, 32'd0);
    chk("midreset co", m_co, 1'b0);
    chk("midreset ovf", m_ovf, 1'b0);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
    send_m(32'hA5A5_A5A5, 32'h5A5A_5A5B, 0, 0, mk(32'h0000_0000, 1, 0, 1));
    wait_drain();

    // Single-stage 8-bit instance
    send_x(8'h80, 8'h80, 0, 0, mk(32'h00, 1, 1, 1));
    send_x(8'h7F, 8'h01, 0, 0, mk(32'h80, 0, 1, 1));
    send_x(8'h05, 8'h07, 1, 1, mk(32'hFE, 0, 0, 1));
    send_x(8'hFF, 8'h01, 1, 0, mk(32'h01, 1, 0, 1));

    // Bit-per-stage 16-bit instance: carry runs of every length, both modes
    send_y(16'hFFFF, 16'h0000, 1, 0, mk(32'h0000, 1, 0, 1));
    send_y(16'h7FFF, 16'h0000, 1, 0, mk(32'h8000, 0, 1, 1));
    for (int k = 0; k <= 16; k++) begin
      ra = (32'd1 << k) - 32'd1;
      send_y(ra[15:0], 16'h0001, 0, 0, model(16, ra, 32'h1, 0, 0, 1));
      rb = 32'd1 << k;
      send_y(16'h0000, rb[15:0], 0, 1, model(16, 32'h0, rb, 0, 1, 1));
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
